// File: rtl/z80_sd_spi_if.sv
// CPU-side IO bus for the SD card SPI master.
// The CPU decoder drives the strobes, address and write data as master.
// The SPI block returns read data as slave.
interface z80_sd_spi_if;
  logic       cpu_wr_tick;
  logic       cpu_rd_tick;
  logic       cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (
    output cpu_wr_tick,
    output cpu_rd_tick,
    output cpu_addr,
    output cpu_din,
    input  cpu_dout
  );

  modport slave (
    input  cpu_wr_tick,
    input  cpu_rd_tick,
    input  cpu_addr,
    input  cpu_din,
    output cpu_dout
  );
endinterface

// File: rtl/z80_sd_spi.sv
// Byte-wide SPI master (mode 0) for the SD card slot.
// The CPU writes DATA to start a byte and polls BUSY in STATUS.
// When the byte is done, the CPU reads the received byte from DATA.
// Optional feature macro: SD_SPI_IRQ_EN (transfer-complete interrupt, irq = done & ien).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; sd_clk low, sd_mosi high
// LO    | SCLK low half-period; MOSI holds the current bit
// HI    | SCLK high half-period; MISO was sampled on entry
module z80_sd_spi #(
  parameter int SLOW_HALF = 23,
  parameter int FAST_HALF = 1
) (
  input  logic          phi,
  input  logic          reset_n,
  z80_sd_spi_if.slave   bus,
  input  logic          sd_miso,
  input  logic          sd_det,
  output logic          sd_mosi,
  output logic          sd_clk,
  output logic          sd_ssel_n,
  output logic          irq
);

  localparam logic [7:0] SLOW_H = 8'(SLOW_HALF);
  localparam logic [7:0] FAST_H = 8'(FAST_HALF);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t     state, state_d;
  logic [7:0] tx, tx_d;
  logic [7:0] rx_sh, rx_sh_d;
  logic [7:0] rx, rx_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] half, half_d;
  logic [2:0] bits, bits_d;
  logic       busy, busy_d;
  logic       done, done_d;
  logic       ovr, ovr_d;
  logic       fast, fast_d;
  logic       sel, sel_d;
  logic       clk_q, clk_d;
  logic       ien;

  logic data_wr, ctrl_wr, stat_rd;

  assign data_wr = bus.cpu_wr_tick & ~bus.cpu_addr;
  assign ctrl_wr = bus.cpu_wr_tick &  bus.cpu_addr;
  assign stat_rd = bus.cpu_rd_tick &  bus.cpu_addr;

  // State and datapath registers; reset puts the pins in their idle levels.
  always_ff @(posedge phi or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tx    <= 8'hFF;
      rx_sh <= 8'hFF;
      rx    <= 8'hFF;
      cnt   <= 8'd0;
      half  <= 8'd0;
      bits  <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovr   <= 1'b0;
      fast  <= 1'b0;
      sel   <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      state <= state_d;
      tx    <= tx_d;
      rx_sh <= rx_sh_d;
      rx    <= rx_d;
      cnt   <= cnt_d;
      half  <= half_d;
      bits  <= bits_d;
      busy  <= busy_d;
      done  <= done_d;
      ovr   <= ovr_d;
      fast  <= fast_d;
      sel   <= sel_d;
      clk_q <= clk_d;
    end
  end

  // Next-state logic: register writes, flag clears, then the shift sequencer.
  // Flag sets come after the clears so that a set in the same cycle as a STATUS read wins.
  always_comb begin
    state_d = state;
    tx_d    = tx;
    rx_sh_d = rx_sh;
    rx_d    = rx;
    cnt_d   = cnt;
    half_d  = half;
    bits_d  = bits;
    busy_d  = busy;
    done_d  = done;
    ovr_d   = ovr;
    fast_d  = fast;
    sel_d   = sel;
    clk_d   = clk_q;

    if (ctrl_wr) begin
      sel_d  = bus.cpu_din[0];
      fast_d = bus.cpu_din[1];
    end

    if (stat_rd) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end

    // A DATA write while a byte is in flight is dropped and flagged.
    if (data_wr && busy) begin
      ovr_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (data_wr) begin
          tx_d    = bus.cpu_din;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = fast ? FAST_H : SLOW_H;
          half_d  = fast ? FAST_H : SLOW_H;
          bits_d  = 3'd7;
          state_d = LO;
        end
      end
      LO: begin
        if (cnt == 8'd0) begin
          clk_d   = 1'b1;
          rx_sh_d = {rx_sh[6:0], sd_miso};
          cnt_d   = half;
          state_d = HI;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      HI: begin
        if (cnt == 8'd0) begin
          clk_d = 1'b0;
          if (bits != 3'd0) begin
            // Shift in ones so MOSI rests high once the byte has gone out.
            tx_d    = {tx[6:0], 1'b1};
            bits_d  = bits - 3'd1;
            cnt_d   = half;
            state_d = LO;
          end else begin
            tx_d    = 8'hFF;
            rx_d    = rx_sh;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SD_SPI_IRQ_EN
  // Interrupt enable bit of CTRL; it exists only when the interrupt is built in.
  always_ff @(posedge phi or negedge reset_n) begin
    if (!reset_n) begin
      ien <= 1'b0;
    end else if (ctrl_wr) begin
      ien <= bus.cpu_din[2];
    end
  end

  assign irq = done & ien;
`else
  assign ien = 1'b0;
  assign irq = 1'b0;
`endif

  assign sd_clk    = clk_q;
  assign sd_mosi   = tx[7];
  assign sd_ssel_n = ~sel;

  assign bus.cpu_dout = bus.cpu_addr ? {busy, sd_det, ovr, done, 1'b0, ien, fast, sel} : rx;

endmodule

// File: tb/tb_z80_sd_spi.sv
// Directed bench for z80_sd_spi.
// Expected bytes and timings are pushed to a scoreboard queue when a transfer is issued.
// They are popped and compared when the transfer finishes.
module tb_z80_sd_spi;

  localparam int SLOW_HALF = 23;
  localparam int FAST_HALF = 1;

  logic phi = 1'b0;
  logic reset_n = 1'b0;
  logic sd_miso = 1'b1;
  logic sd_det  = 1'b1;
  logic sd_mosi, sd_clk, sd_ssel_n, irq;

  z80_sd_spi_if bus();

  z80_sd_spi #(.SLOW_HALF(SLOW_HALF), .FAST_HALF(FAST_HALF)) dut (
    .phi       (phi),
    .reset_n   (reset_n),
    .bus       (bus),
    .sd_miso   (sd_miso),
    .sd_det    (sd_det),
    .sd_mosi   (sd_mosi),
    .sd_clk    (sd_clk),
    .sd_ssel_n (sd_ssel_n),
    .irq       (irq)
  );

  initial forever #5 phi = ~phi;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
    int         cycles;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge phi);
    bus.cpu_addr    = a;
    bus.cpu_din     = d;
    bus.cpu_wr_tick = 1'b1;
    @(negedge phi);
    bus.cpu_wr_tick = 1'b0;
    bus.cpu_addr    = 1'b1;
  endtask

  task automatic peek(input logic a, output logic [7:0] v);
    @(negedge phi);
    bus.cpu_addr = a;
    #1;
    v = bus.cpu_dout;
    bus.cpu_addr = 1'b1;
  endtask

  task automatic status_rd(output logic [7:0] v);
    @(negedge phi);
    bus.cpu_addr    = 1'b1;
    bus.cpu_rd_tick = 1'b1;
    #1;
    v = bus.cpu_dout;
    @(negedge phi);
    bus.cpu_rd_tick = 1'b0;
  endtask

  // Runs one byte: drives MISO on SCLK falls, captures MOSI on SCLK rises, counts busy cycles.
  task automatic xfer(input logic [7:0] txb, input logic [7:0] mpat,
                      input int second_at, input logic [7:0] second_b,
                      input int rd_at, input int peek_at, input logic [7:0] peek_exp,
                      input int abort_rises,
                      output logic [7:0] mcap, output int cyc, output int nrise,
                      output int per, output logic irq_busy, output logic irq_fall,
                      output logic timed_out);
    int   idx;
    int   first_rise;
    logic prev_clk;
    mcap = 8'h00; cyc = 0; nrise = 0; per = 0;
    irq_busy = 1'b0; irq_fall = 1'b0; timed_out = 1'b1;
    idx = 0; first_rise = 0;
    sd_miso = mpat[7];
    @(negedge phi);
    bus.cpu_addr    = 1'b0;
    bus.cpu_din     = txb;
    bus.cpu_wr_tick = 1'b1;
    prev_clk = sd_clk;
    for (int t = 0; t < 2000; t++) begin
      @(negedge phi);
      bus.cpu_wr_tick = 1'b0;
      bus.cpu_rd_tick = 1'b0;
      bus.cpu_addr    = 1'b1;
      #1;
      if (!bus.cpu_dout[7]) begin
        irq_fall  = irq;
        timed_out = 1'b0;
        break;
      end
      cyc++;
      if (irq) irq_busy = 1'b1;
      if (sd_clk && !prev_clk) begin
        mcap = {mcap[6:0], sd_mosi};
        nrise++;
        if (nrise == 1) first_rise = cyc;
        else if (nrise == 2) per = cyc - first_rise;
      end
      if (!sd_clk && prev_clk) begin
        idx++;
        if (idx < 8) sd_miso = mpat[7 - idx];
      end
      prev_clk = sd_clk;
      if (abort_rises > 0 && nrise == abort_rises) begin
        timed_out = 1'b0;
        break;
      end
      if (cyc == peek_at) begin
        bus.cpu_addr = 1'b0;
        #1;
        chk("data_read_while_busy", {24'd0, bus.cpu_dout}, {24'd0, peek_exp});
        bus.cpu_addr = 1'b1;
      end
      if (cyc == second_at) begin
        bus.cpu_addr    = 1'b0;
        bus.cpu_din     = second_b;
        bus.cpu_wr_tick = 1'b1;
      end
      if (cyc == rd_at) bus.cpu_rd_tick = 1'b1;
    end
    sd_miso = 1'b1;
  endtask

  initial begin
    logic [7:0] v, mcap;
    int         cyc, nrise, per;
    logic       irq_busy, irq_fall, tmo;
    exp_t       e;

    bus.cpu_wr_tick = 1'b0;
    bus.cpu_rd_tick = 1'b0;
    bus.cpu_addr    = 1'b1;
    bus.cpu_din     = 8'h00;

    // 1: reset values
    repeat (3) @(negedge phi);
    #1;
    chk("rst_ssel_n", {31'd0, sd_ssel_n}, 32'd1);
    chk("rst_sclk", {31'd0, sd_clk}, 32'd0);
    chk("rst_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    peek(1'b0, v);
    chk("rst_data", {24'd0, v}, 32'hFF);
    peek(1'b1, v);
    chk("rst_status", {24'd0, v}, 32'h40);

    // 2: fast byte A5 / miso 3C, STATUS read lands on the completion edge
    bus_wr(1'b1, 8'h03);
    #1;
    chk("ctrl_ssel_n", {31'd0, sd_ssel_n}, 32'd0);
    sb_q.push_back('{rx: 8'h3C, mosi: 8'hA5, cycles: 16 * (FAST_HALF + 1)});
    xfer(8'hA5, 8'h3C, -1, 8'h00, 32, -1, 8'h00, 0, mcap, cyc, nrise, per, irq_busy, irq_fall, tmo);
    e = sb_q.pop_front();
    chk("fast_timeout", {31'd0, tmo}, 32'd0);
    chk("fast_mosi", {24'd0, mcap}, {24'd0, e.mosi});
    chk("fast_cycles", cyc, e.cycles);
    peek(1'b0, v);
    chk("fast_rx", {24'd0, v}, {24'd0, e.rx});
    peek(1'b1, v);
    chk("fast_status_done_wins", {24'd0, v}, 32'h53);
    chk("fast_irq_off", {31'd0, irq}, 32'd0);
    status_rd(v);
    peek(1'b1, v);
    chk("done_cleared", {24'd0, v}, 32'h43);

    // 3: slow byte FF / miso 81
    bus_wr(1'b1, 8'h01);
    sb_q.push_back('{rx: 8'h81, mosi: 8'hFF, cycles: 16 * (SLOW_HALF + 1)});
    xfer(8'hFF, 8'h81, -1, 8'h00, -1, -1, 8'h00, 0, mcap, cyc, nrise, per, irq_busy, irq_fall, tmo);
    e = sb_q.pop_front();
    chk("slow_timeout", {31'd0, tmo}, 32'd0);
    chk("slow_mosi", {24'd0, mcap}, {24'd0, e.mosi});
    chk("slow_cycles", cyc, e.cycles);
    chk("slow_pulses", nrise, 8);
    chk("slow_period", per, 2 * (SLOW_HALF + 1));
    repeat (5) @(negedge phi);
    chk("slow_sclk_idle", {31'd0, sd_clk}, 32'd0);
    peek(1'b0, v);
    chk("slow_rx", {24'd0, v}, {24'd0, e.rx});
    peek(1'b1, v);
    chk("slow_status", {24'd0, v}, 32'h51);

    // 4: overrun write mid-byte, DATA read while busy
    sb_q.push_back('{rx: 8'h5A, mosi: 8'h12, cycles: 16 * (SLOW_HALF + 1)});
    xfer(8'h12, 8'h5A, 100, 8'h34, -1, 50, 8'h81, 0, mcap, cyc, nrise, per, irq_busy, irq_fall, tmo);
    e = sb_q.pop_front();
    chk("ovr_timeout", {31'd0, tmo}, 32'd0);
    chk("ovr_mosi", {24'd0, mcap}, {24'd0, e.mosi});
    chk("ovr_cycles", cyc, e.cycles);
    peek(1'b0, v);
    chk("ovr_rx", {24'd0, v}, {24'd0, e.rx});
    status_rd(v);
    chk("ovr_status", {24'd0, v}, 32'h71);
    peek(1'b1, v);
    chk("ovr_cleared", {24'd0, v}, 32'h41);

    // 5: reset after 3 bits, then a clean byte
    bus_wr(1'b1, 8'h03);
    sb_q.push_back('{rx: 8'hA5, mosi: 8'h5A, cycles: 16 * (FAST_HALF + 1)});
    xfer(8'h5A, 8'hA5, -1, 8'h00, -1, -1, 8'h00, 3, mcap, cyc, nrise, per, irq_busy, irq_fall, tmo);
    e = sb_q.pop_front();
    chk("abort_rises", nrise, 3);
    chk("abort_timeout", {31'd0, tmo}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_sclk", {31'd0, sd_clk}, 32'd0);
    chk("abort_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("abort_ssel_n", {31'd0, sd_ssel_n}, 32'd1);
    chk("abort_status", {24'd0, bus.cpu_dout}, 32'h40);
    bus.cpu_addr = 1'b0;
    #1;
    chk("abort_data", {24'd0, bus.cpu_dout}, 32'hFF);
    bus.cpu_addr = 1'b1;
    @(negedge phi);
    reset_n = 1'b1;
    bus_wr(1'b1, 8'h03);
    sb_q.push_back('{rx: 8'h96, mosi: 8'hC3, cycles: 16 * (FAST_HALF + 1)});
    xfer(8'hC3, 8'h96, -1, 8'h00, -1, -1, 8'h00, 0, mcap, cyc, nrise, per, irq_busy, irq_fall, tmo);
    e = sb_q.pop_front();
    chk("post_rst_timeout", {31'd0, tmo}, 32'd0);
    chk("post_rst_mosi", {24'd0, mcap}, {24'd0, e.mosi});
    chk("post_rst_cycles", cyc, e.cycles);
    peek(1'b0, v);
    chk("post_rst_rx", {24'd0, v}, {24'd0, e.rx});
    status_rd(v);

    // 6: transfer-complete interrupt
    bus_wr(1'b1, 8'h07);
    peek(1'b1, v);
`ifdef SD_SPI_IRQ_EN
    chk("irq_ctrl", {24'd0, v}, 32'h47);
`else
    chk("irq_ctrl", {24'd0, v}, 32'h43);
`endif
    sb_q.push_back('{rx: 8'h00, mosi: 8'h00, cycles: 16 * (FAST_HALF + 1)});
    xfer(8'h00, 8'h00, -1, 8'h00, -1, -1, 8'h00, 0, mcap, cyc, nrise, per, irq_busy, irq_fall, tmo);
    e = sb_q.pop_front();
    chk("irq_xfer_timeout", {31'd0, tmo}, 32'd0);
    chk("irq_xfer_cycles", cyc, e.cycles);
    peek(1'b0, v);
    chk("irq_xfer_rx", {24'd0, v}, {24'd0, e.rx});
    chk("irq_low_while_busy", {31'd0, irq_busy}, 32'd0);
`ifdef SD_SPI_IRQ_EN
    chk("irq_at_busy_fall", {31'd0, irq_fall}, 32'd1);
`else
    chk("irq_at_busy_fall", {31'd0, irq_fall}, 32'd0);
`endif
    status_rd(v);
    #1;
    chk("irq_after_status_rd", {31'd0, irq}, 32'd0);

    repeat (4) @(negedge phi);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
